// File: rtl/pc_resolve_pkg.sv
// Shared types and helpers for the PC resolve unit.
//   branch_cond_e : 3-bit branch condition codes
//   FLAG_*        : bit positions inside the {Z,V,N} ALU flag vector
//   state_e       : handshake FSM states
//   eval_cond     : evaluates a branch condition against the sampled flags
package pc_resolve_pkg;

   typedef enum logic [2:0] {
      CondEq  = 3'd0,
      CondLt  = 3'd1,
      CondGt  = 3'd2,
      CondO   = 3'd3,
      CondNe  = 3'd4,
      CondGeq = 3'd5,
      CondLeq = 3'd6,
      CondT   = 3'd7
   } branch_cond_e;

   localparam int unsigned FLAG_Z = 2;
   localparam int unsigned FLAG_V = 1;
   localparam int unsigned FLAG_N = 0;

   typedef enum logic {
      IDLE = 1'b0,
      DONE = 1'b1
   } state_e;

   function automatic logic eval_cond(input branch_cond_e cond, input logic [2:0] flags);
      logic z, v, n, lt;
      z  = flags[FLAG_Z];
      v  = flags[FLAG_V];
      n  = flags[FLAG_N];
      // Signed less-than as seen by the ALU flags (no overflow correction on V).
      lt = n & ~v;
      unique case (cond)
         CondEq:  eval_cond = z;
         CondLt:  eval_cond = lt;
         CondGt:  eval_cond = ~z & ~n & ~v;
         CondO:   eval_cond = v;
         CondNe:  eval_cond = ~z;
         CondGeq: eval_cond = ~lt;
         CondLeq: eval_cond = z | lt;
         CondT:   eval_cond = 1'b1;
      endcase
   endfunction

endpackage

// File: rtl/pc_resolve_ras_stack.sv
// Circular return-address stack.
//   clk, rst_n : clock, async active-low reset (empties the stack)
//   push       : store push_data on top; when full the oldest entry is overwritten
//   pop        : discard the top entry (ignored when empty)
//   top        : current top entry
//   count      : number of valid entries (saturates at DEPTH)
//   full/empty : count == DEPTH / count == 0
module ras_stack #(
   parameter int unsigned W     = 16,
   parameter int unsigned DEPTH = 8,
   parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic             pop,
   input  logic [W-1:0]     push_data,
   output logic [W-1:0]     top,
   output logic [CNT_W-1:0] count,
   output logic             full,
   output logic             empty
);

   localparam int unsigned PtrW = $clog2(DEPTH);

   logic [W-1:0]     mem_q [DEPTH];
   // ptr_q is the next free slot; the top entry sits one below it.
   logic [PtrW-1:0]  ptr_q;
   logic [CNT_W-1:0] cnt_q;

   assign full  = (cnt_q == CNT_W'(DEPTH));
   assign empty = (cnt_q == '0);
   assign count = cnt_q;
   assign top   = mem_q[ptr_q - PtrW'(1)];

   // DEPTH is a power of two, so the pointer wraps for free.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_q <= '0;
         cnt_q <= '0;
         for (int i = 0; i < int'(DEPTH); i++) begin
            mem_q[i] <= '0;
         end
      end else if (push) begin
         mem_q[ptr_q] <= push_data;
         ptr_q        <= ptr_q + PtrW'(1);
         if (!full) begin
            cnt_q <= cnt_q + CNT_W'(1);
         end
      end else if (pop && !empty) begin
         ptr_q <= ptr_q - PtrW'(1);
         cnt_q <= cnt_q - CNT_W'(1);
      end
   end

endmodule

// File: rtl/pc_resolve_ras.sv
// Branch / call / return redirect resolution for the fetch stage.
//   req_valid/req_ready : request handshake from ID/EX (one request per 2 cycles)
//   branch/call/ret     : request kind, priority branch > call > ret
//   branch_cond, flags  : condition code and ALU {Z,V,N}, sampled at acceptance
//   pc_in, sign_ext     : requesting PC and signed branch offset
//   call_target         : low bits of the call destination
//   flush               : cancels the visible result / blocks acceptance
//   err_clr             : clears the sticky RAS error bits
//   pc_update, pc_src   : redirect target and take-enable, valid while update_done
//   update_done         : one-cycle result strobe
//   ras_count           : valid RAS entries; ras_ovf/ras_unf sticky push/pop errors
module pc_resolve_ras
   import pc_resolve_pkg::*;
#(
   parameter int unsigned PC_W  = 16,
   parameter int unsigned TGT_W = 12,
   parameter int unsigned DEPTH = 8,
   parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic             branch,
   input  logic [2:0]       branch_cond,
   input  logic             call,
   input  logic             ret,
   input  logic [PC_W-1:0]  pc_in,
   input  logic [PC_W-1:0]  sign_ext,
   input  logic [TGT_W-1:0] call_target,
   input  logic [2:0]       flags,
   input  logic             flush,
   input  logic             err_clr,
   output logic [PC_W-1:0]  pc_update,
   output logic             pc_src,
   output logic             update_done,
   output logic [CNT_W-1:0] ras_count,
   output logic             ras_ovf,
   output logic             ras_unf
);

   state_e          state_q, state_d;
   logic [PC_W-1:0] pc_q, pc_d;
   logic            src_q, src_d;
   logic            ovf_q, ovf_d;
   logic            unf_q, unf_d;

   logic            accept;
   logic            ras_push, ras_pop;
   logic            ovf_ev, unf_ev;
   logic [PC_W-1:0] ras_top;
   logic            ras_full, ras_empty;
   logic            show;

   ras_stack #(
      .W     (PC_W),
      .DEPTH (DEPTH),
      .CNT_W (CNT_W)
   ) u_ras (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (ras_push),
      .pop       (ras_pop),
      .push_data (pc_in + PC_W'(1)),
      .top       (ras_top),
      .count     (ras_count),
      .full      (ras_full),
      .empty     (ras_empty)
   );

   assign accept = (state_q == IDLE) && req_valid && !flush;

   always_comb begin
      state_d  = state_q;
      pc_d     = pc_q;
      src_d    = src_q;
      ras_push = 1'b0;
      ras_pop  = 1'b0;
      ovf_ev   = 1'b0;
      unf_ev   = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (accept) begin
               state_d = DONE;
               pc_d    = '0;
               src_d   = 1'b0;
               if (branch) begin
                  pc_d  = pc_in + PC_W'(1) + sign_ext;
                  src_d = eval_cond(branch_cond_e'(branch_cond), flags);
               end else if (call) begin
                  pc_d     = {pc_in[PC_W-1:TGT_W], call_target};
                  src_d    = 1'b1;
                  ras_push = 1'b1;
                  ovf_ev   = ras_full;
               end else if (ret) begin
                  if (!ras_empty) begin
                     pc_d    = ras_top;
                     src_d   = 1'b1;
                     ras_pop = 1'b1;
                  end else begin
                     unf_ev = 1'b1;
                  end
               end
            end
         end
         DONE: state_d = IDLE;
      endcase
      // A new error event on the same edge beats err_clr.
      ovf_d = ovf_ev | (ovf_q & ~err_clr);
      unf_d = unf_ev | (unf_q & ~err_clr);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         pc_q    <= '0;
         src_q   <= 1'b0;
         ovf_q   <= 1'b0;
         unf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         src_q   <= src_d;
         ovf_q   <= ovf_d;
         unf_q   <= unf_d;
      end
   end

   // rst_n is folded in so every output reads 0 while reset is held.
   always_comb begin
      show        = (state_q == DONE) && !flush;
      req_ready   = rst_n && (state_q == IDLE) && !flush;
      update_done = show;
      pc_src      = show & src_q;
      pc_update   = show ? pc_q : '0;
      ras_ovf     = ovf_q;
      ras_unf     = unf_q;
   end

endmodule

// File: tb/tb_pc_resolve_ras.sv
module tb_pc_resolve_ras;

   localparam int unsigned PC_W  = 16;
   localparam int unsigned TGT_W = 12;
   localparam int unsigned DEPTH = 8;
   localparam int unsigned CNT_W = $clog2(DEPTH + 1);
   localparam int          PC_MOD  = 2 ** PC_W;
   localparam int          TGT_MOD = 2 ** TGT_W;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             req_valid = 1'b0;
   logic             req_ready;
   logic             branch = 1'b0;
   logic [2:0]       branch_cond = 3'd0;
   logic             call = 1'b0;
   logic             ret = 1'b0;
   logic [PC_W-1:0]  pc_in = '0;
   logic [PC_W-1:0]  sign_ext = '0;
   logic [TGT_W-1:0] call_target = '0;
   logic [2:0]       flags = 3'd0;
   logic             flush = 1'b0;
   logic             err_clr = 1'b0;
   logic [PC_W-1:0]  pc_update;
   logic             pc_src;
   logic             update_done;
   logic [CNT_W-1:0] ras_count;
   logic             ras_ovf;
   logic             ras_unf;

   int checks = 0;
   int errors = 0;

   // Reference model: the RAS as a queue, oldest entry at the front.
   int ras_m[$];
   bit m_ovf = 1'b0;
   bit m_unf = 1'b0;

   int obs_pc;
   bit obs_src;
   int acc;

   pc_resolve_ras #(
      .PC_W  (PC_W),
      .TGT_W (TGT_W),
      .DEPTH (DEPTH),
      .CNT_W (CNT_W)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .branch      (branch),
      .branch_cond (branch_cond),
      .call        (call),
      .ret         (ret),
      .pc_in       (pc_in),
      .sign_ext    (sign_ext),
      .call_target (call_target),
      .flags       (flags),
      .flush       (flush),
      .err_clr     (err_clr),
      .pc_update   (pc_update),
      .pc_src      (pc_src),
      .update_done (update_done),
      .ras_count   (ras_count),
      .ras_ovf     (ras_ovf),
      .ras_unf     (ras_unf)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic bit cond_ok(input logic [2:0] cond, input logic [2:0] f);
      bit z, v, n;
      z = f[2];
      v = f[1];
      n = f[0];
      case (cond)
         3'd0:    return z;
         3'd1:    return n && !v;
         3'd2:    return !z && !n && !v;
         3'd3:    return v;
         3'd4:    return !z;
         3'd5:    return !(n && !v);
         3'd6:    return z || (n && !v);
         default: return 1'b1;
      endcase
   endfunction

   task automatic model_req(input bit b, input bit c, input bit r, input logic [2:0] cond,
                            input logic [2:0] f, input int pcin, input int se, input int tgt,
                            input bit clr, output int epc, output bit esrc);
      bit ev_ovf, ev_unf;
      epc = 0;
      esrc = 1'b0;
      ev_ovf = 1'b0;
      ev_unf = 1'b0;
      if (b) begin
         epc  = (pcin + 1 + se) % PC_MOD;
         esrc = cond_ok(cond, f);
      end else if (c) begin
         epc  = (pcin / TGT_MOD) * TGT_MOD + tgt;
         esrc = 1'b1;
         if (ras_m.size() == DEPTH) begin
            void'(ras_m.pop_front());
            ev_ovf = 1'b1;
         end
         ras_m.push_back((pcin + 1) % PC_MOD);
      end else if (r) begin
         if (ras_m.size() > 0) begin
            epc  = ras_m.pop_back();
            esrc = 1'b1;
         end else begin
            ev_unf = 1'b1;
         end
      end
      m_ovf = ev_ovf || (m_ovf && !clr);
      m_unf = ev_unf || (m_unf && !clr);
   endtask

   task automatic do_req(input bit b, input bit c, input bit r, input logic [2:0] cond,
                         input logic [2:0] f, input int pcin, input int se, input int tgt,
                         input bit clr, input string tag);
      int  epc;
      bit  esrc;
      @(negedge clk);
      check({tag, ".ready"}, 32'(req_ready), 32'd1);
      branch      = b;
      call        = c;
      ret         = r;
      branch_cond = cond;
      flags       = f;
      pc_in       = PC_W'(pcin);
      sign_ext    = PC_W'(se);
      call_target = TGT_W'(tgt);
      err_clr     = clr;
      req_valid   = 1'b1;
      model_req(b, c, r, cond, f, pcin, se, tgt, clr, epc, esrc);
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      branch    = 1'b0;
      call      = 1'b0;
      ret       = 1'b0;
      err_clr   = 1'b0;
      obs_pc    = int'(pc_update);
      obs_src   = pc_src;
      check({tag, ".done"}, 32'(update_done), 32'd1);
      check({tag, ".pc"}, 32'(pc_update), 32'(epc));
      check({tag, ".src"}, 32'(pc_src), 32'(esrc));
      check({tag, ".count"}, 32'(ras_count), 32'(ras_m.size()));
      check({tag, ".ovf"}, 32'(ras_ovf), 32'(m_ovf));
      check({tag, ".unf"}, 32'(ras_unf), 32'(m_unf));
      @(posedge clk);
      #1;
      check({tag, ".idle_done"}, 32'(update_done), 32'd0);
      check({tag, ".idle_pc"}, 32'(pc_update), 32'd0);
   endtask

   initial begin
      // Reset state: every output low while reset is held.
      #2;
      check("rst.ready", 32'(req_ready), 32'd0);
      check("rst.done", 32'(update_done), 32'd0);
      check("rst.pc", 32'(pc_update), 32'd0);
      check("rst.src", 32'(pc_src), 32'd0);
      check("rst.count", 32'(ras_count), 32'd0);
      check("rst.flags", {30'd0, ras_ovf, ras_unf}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("rst.ready_after", 32'(req_ready), 32'd1);

      // Branch EQ taken and not taken.
      do_req(1, 0, 0, 3'd0, 3'b100, 'h0010, 'hFFFC, 0, 0, "beq_t");
      check("beq_t.lit_pc", 32'(obs_pc), 32'h000D);
      check("beq_t.lit_src", 32'(obs_src), 32'd1);
      do_req(1, 0, 0, 3'd0, 3'b000, 'h0010, 'hFFFC, 0, 0, "beq_nt");
      check("beq_nt.lit_src", 32'(obs_src), 32'd0);

      // Call then return.
      do_req(0, 1, 0, 3'd0, 3'd0, 'h3456, 0, 'hABC, 0, "call");
      check("call.lit_pc", 32'(obs_pc), 32'h3ABC);
      check("call.lit_count", 32'(ras_count), 32'd1);
      do_req(0, 0, 1, 3'd0, 3'd0, 0, 0, 0, 0, "ret");
      check("ret.lit_pc", 32'(obs_pc), 32'h3457);
      check("ret.lit_count", 32'(ras_count), 32'd0);

      // Overflow then drain to underflow.
      for (int i = 0; i <= 8; i++) begin
         do_req(0, 1, 0, 3'd0, 3'd0, i, 0, 0, 0, "ovf_call");
      end
      check("ovf.lit_ovf", 32'(ras_ovf), 32'd1);
      check("ovf.lit_count", 32'(ras_count), 32'd8);
      for (int k = 0; k < 8; k++) begin
         do_req(0, 0, 1, 3'd0, 3'd0, 0, 0, 0, 0, "ovf_ret");
         check("ovf_ret.lit_pc", 32'(obs_pc), 32'(9 - k));
      end
      do_req(0, 0, 1, 3'd0, 3'd0, 0, 0, 0, 0, "unf_ret");
      check("unf.lit_src", 32'(obs_src), 32'd0);
      check("unf.lit_unf", 32'(ras_unf), 32'd1);

      // Handshake: valid held for 6 cycles gives 3 acceptances.
      acc = 0;
      @(negedge clk);
      req_valid = 1'b1;
      for (int i = 0; i < 6; i++) begin
         #1;
         check("hs.ready", 32'(req_ready), 32'((i % 2) == 0));
         @(posedge clk);
         #1;
         if (update_done) acc++;
         @(negedge clk);
      end
      req_valid = 1'b0;
      check("hs.accepts", 32'(acc), 32'd3);

      // Flush in DONE after a call: result hidden, push kept.
      begin
         int  epc;
         bit  esrc;
         call        = 1'b1;
         pc_in       = 16'h1234;
         call_target = 12'h055;
         req_valid   = 1'b1;
         model_req(0, 1, 0, 3'd0, 3'd0, 'h1234, 0, 'h055, 0, epc, esrc);
         @(posedge clk);
         #1;
         req_valid = 1'b0;
         call      = 1'b0;
         flush     = 1'b1;
         #1;
         check("fl_done.done", 32'(update_done), 32'd0);
         check("fl_done.src", 32'(pc_src), 32'd0);
         check("fl_done.pc", 32'(pc_update), 32'd0);
         check("fl_done.count", 32'(ras_count), 32'(ras_m.size()));
         check("fl_done.lit_count", 32'(ras_count), 32'd1);
         @(negedge clk);
         flush = 1'b0;
      end

      // Flush in IDLE blocks acceptance.
      @(negedge clk);
      flush     = 1'b1;
      req_valid = 1'b1;
      call      = 1'b1;
      #1;
      check("fl_idle.ready", 32'(req_ready), 32'd0);
      @(posedge clk);
      #1;
      check("fl_idle.done", 32'(update_done), 32'd0);
      check("fl_idle.count", 32'(ras_count), 32'd1);
      flush     = 1'b0;
      req_valid = 1'b0;
      call      = 1'b0;

      // err_clr clears both sticky bits.
      @(negedge clk);
      err_clr = 1'b1;
      @(posedge clk);
      #1;
      err_clr = 1'b0;
      m_ovf = 1'b0;
      m_unf = 1'b0;
      check("clr.ovf", 32'(ras_ovf), 32'd0);
      check("clr.unf", 32'(ras_unf), 32'd0);

      // Wrap and priority: branch T beats call, nothing pushed.
      do_req(1, 1, 0, 3'd7, 3'd0, 'hFFFF, 0, 'h123, 0, "wrap");
      check("wrap.lit_pc", 32'(obs_pc), 32'd0);
      check("wrap.lit_src", 32'(obs_src), 32'd1);
      check("wrap.lit_count", 32'(ras_count), 32'd1);

      // Reset in DONE empties the RAS immediately.
      @(negedge clk);
      call      = 1'b1;
      pc_in     = 16'h0100;
      req_valid = 1'b1;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      call      = 1'b0;
      rst_n     = 1'b0;
      #1;
      check("mid_rst.done", 32'(update_done), 32'd0);
      check("mid_rst.pc", 32'(pc_update), 32'd0);
      check("mid_rst.count", 32'(ras_count), 32'd0);
      ras_m.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;

      // Randomised requests against the model.
      for (int n = 0; n < 300; n++) begin
         int sel;
         bit b, c, r, clr;
         sel = int'($urandom_range(0, 3));
         b = (sel == 0);
         c = (sel == 1);
         r = (sel == 2);
         if ($urandom_range(0, 7) == 0) begin
            b = b | $urandom_range(0, 1) == 1;
            c = c | $urandom_range(0, 1) == 1;
            r = r | $urandom_range(0, 1) == 1;
         end
         clr = ($urandom_range(0, 15) == 0);
         do_req(b, c, r, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                int'($urandom_range(0, PC_MOD - 1)), int'($urandom_range(0, PC_MOD - 1)),
                int'($urandom_range(0, TGT_MOD - 1)), clr, "rnd");
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/pc_resolve_ras.md
Name: pc_resolve_ras

Overview:
Parametrised successor to the combinational PC update logic. Resolves branch, call and return redirects for the fetch stage from the ID/EX request and ALU flags, with a registered one-cycle result handshake. Holds an internal circular return-address stack (RAS), so calls push and returns pop locally, replacing the PC stack pointer supplied from MEM/WB. Sits between the ID/EX register / ALU and the PC mux, and reports status to the control unit.

Parameters:
PC_W, 16, PC and offset width
TGT_W, 12, call target field width; must be < PC_W
DEPTH, 8, RAS entries; power of two, >= 2
CNT_W, $clog2(DEPTH+1), width of ras_count

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  request present (ID/EX)
req_ready  out  1  unit can accept a request
branch  in  1  request is conditional branch
branch_cond  in  3  EQ=0 LT=1 GT=2 O=3 NE=4 GEQ=5 LEQ=6 T=7
call  in  1  request is call
ret  in  1  request is return
pc_in  in  PC_W  PC of the requesting instruction
sign_ext  in  PC_W  signed branch offset
call_target  in  TGT_W  call target low bits
flags  in  3  ALU flags {Z,V,N}
flush  in  1  cancel a pending result
err_clr  in  1  clear the sticky error bits
pc_update  out  PC_W  redirect target
pc_src  out  1  take pc_update
update_done  out  1  one-cycle result strobe; unhalts the pipe
ras_count  out  CNT_W  valid RAS entries
ras_ovf  out  1  sticky: a push hit a full RAS
ras_unf  out  1  sticky: a pop hit an empty RAS

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on rst_n. During reset, all outputs are 0, the FSM is IDLE, ras_count is 0 and the pointers are 0.
- FSM has two states:
  - IDLE: req_ready=1. On req_valid, accept the request, compute the result, update the RAS, then go to DONE.
  - DONE: req_ready=0, update_done=1, pc_update and pc_src hold the registered result. Always return to IDLE next cycle.
- Latency and throughput: result one cycle after acceptance; at most one request every 2 cycles.
- Priority: branch > call > ret. Flags are sampled at acceptance.
- Branch:
  - pc_update = pc_in + 1 + sign_ext, mod 2^PC_W (wrap, no saturation).
  - pc_src = condition: EQ Z; NE !Z; LT N&!V; GT !Z&!N&!V; LEQ Z|(N&!V); GEQ !(N&!V); O V; T 1.
- Call:
  - pc_update = {pc_in[PC_W-1:TGT_W], call_target}; pc_src=1.
  - Push pc_in+1 (wrapped).
- Ret, RAS non-empty: pc_update = top entry; pc_src=1; pop.
- Ret, RAS empty: pc_update=0, pc_src=0, ras_unf set; ras_count and pointers unchanged.
- Push when full: overwrite the oldest entry (circular), top pointer advances, ras_count stays DEPTH, ras_ovf set.
- Accepted request with none of branch/call/ret: DONE still pulses update_done with pc_src=0 and pc_update=0.
- Outside DONE: pc_update=0, pc_src=0, update_done=0.
- flush:
  - In DONE: force update_done, pc_src and pc_update to 0 in that cycle. The RAS change made at acceptance is not rolled back.
  - In IDLE: blocks acceptance that cycle (req_ready=0).
- err_clr: clears ras_ovf/ras_unf on the next edge. If it coincides with a new error event, the error wins.
- Reset asserted mid-operation (DONE): immediate return to the reset state; the RAS is emptied.

Decomposition:
- Package pc_resolve_pkg holds:
  - the branch_cond_e enum with the 8 codes;
  - flag index constants (FLAG_Z=2, FLAG_V=1, FLAG_N=0);
  - the state_e enum {IDLE, DONE}.
- One sub-module, ras_stack: parametrised circular stack with push/pop, top, count, full, empty and overwrite-on-full.
- Condition evaluation stays inline as a combinational function in the package.

Test Plan:
- Branch EQ: pc_in=0x0010, sign_ext=0xFFFC, flags=3'b100 -> next cycle update_done=1, pc_src=1, pc_update=0x000D. Same request with flags=0 -> pc_src=0.
- Call then ret: call pc_in=0x3456, call_target=0xABC -> pc_update=0x3ABC, ras_count=1. Then ret -> pc_update=0x3457, pc_src=1, ras_count=0.
- Overflow: 9 calls with pc_in=0..8 (DEPTH=8) -> ras_ovf=1, ras_count=8. 8 rets return 9,8,...,2. A 9th ret -> pc_src=0, ras_unf=1.
- Handshake: req_valid held high for 6 cycles -> exactly 3 acceptances, with req_ready alternating 1,0.
- Flush in DONE after a call -> update_done=0 that cycle, but ras_count=1. err_clr -> sticky bits clear.
- Wrap and priority: pc_in=0xFFFF, sign_ext=0, branch=1, cond=T with call=1 -> pc_update=0x0000, pc_src=1, no push.
